// File: rtl/multiplier_seq_param.sv
// multiplier_seq_param: signed (two's-complement) sequential add-shift multiplier.
// Computes {X, Aval, Bval} = S * B over WIDTH compute cycles, one multiplier bit per cycle.
// The add and the arithmetic right shift happen in the same cycle. On the final step the
// multiplicand is subtracted, because the top multiplier bit carries negative weight.
//
// Optional build macro: MULT_ACCUM_EN. When it is defined, the start of a run keeps the
// previous A/X, so the result becomes S*B + sign_ext(A_prev).
//
// Ports:
//   Clk               in   system clock
//   Reset_USH         in   asynchronous active-low reset, clears all state
//   Run_USH           in   active-low start button (raw)
//   ClearA_LoadB_USH  in   active-low: A<=0, X<=0, B<=S (raw)
//   S_USH             in   [WIDTH] multiplicand / load value from switches (raw)
//   Aval              out  [WIDTH] upper product half
//   Bval              out  [WIDTH] lower product half / multiplier
//   X                 out  sign-extension bit of A
//   Busy              out  high in RUN_INIT and COMPUTE
module multiplier_seq_param #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             Reset_USH,
    input  logic             Run_USH,
    input  logic             ClearA_LoadB_USH,
    input  logic [WIDTH-1:0] S_USH,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {StIdle, StClearLoad, StRunInit, StCompute, StDone} state_e;

    // Synchroniser chains. They reset to all ones, which reads as "buttons released".
    logic [SYNC_STAGES-1:0] run_sync_q;
    logic [SYNC_STAGES-1:0] clr_sync_q;
    logic [WIDTH-1:0]       s_sync_q [SYNC_STAGES];

    logic             run_s, clr_s, run_prev_q, run_fall;
    logic [WIDTH-1:0] s_s;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
    logic             x_q, x_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             last_step;
    logic [WIDTH:0]   a_ext, addend, sum;

    assign run_s = run_sync_q[SYNC_STAGES-1];
    assign clr_s = clr_sync_q[SYNC_STAGES-1];
    assign s_s   = s_sync_q[SYNC_STAGES-1];

    // A start is accepted only on a release-to-press transition of the synced button.
    assign run_fall = run_prev_q & ~run_s;

    always_ff @(posedge Clk or negedge Reset_USH) begin
        if (!Reset_USH) begin
            run_sync_q <= '1;
            clr_sync_q <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) s_sync_q[i] <= '1;
            run_prev_q <= 1'b1;
        end else begin
            run_sync_q  <= {run_sync_q[SYNC_STAGES-2:0], Run_USH};
            clr_sync_q  <= {clr_sync_q[SYNC_STAGES-2:0], ClearA_LoadB_USH};
            s_sync_q[0] <= S_USH;
            for (int i = 1; i < SYNC_STAGES; i++) s_sync_q[i] <= s_sync_q[i-1];
            run_prev_q  <= run_s;
        end
    end

    always_ff @(posedge Clk or negedge Reset_USH) begin
        if (!Reset_USH) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            x_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last_step = (cnt_q == CntW'(WIDTH - 1));
    assign a_ext     = {a_q[WIDTH-1], a_q};
    assign addend    = b_q[0] ? {m_q[WIDTH-1], m_q} : '0;
    assign sum       = last_step ? (a_ext - addend) : (a_ext + addend);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (!clr_s) begin
                    state_d = StClearLoad;
                end else if (run_fall) begin
                    state_d = StRunInit;
                end
            end
            StClearLoad: begin
                a_d = '0;
                x_d = 1'b0;
                b_d = s_s;
                if (clr_s) state_d = StIdle;
            end
            StRunInit: begin
`ifdef MULT_ACCUM_EN
                // A/X kept: the old upper half is accumulated into the new product.
`else
                a_d = '0;
                x_d = 1'b0;
`endif
                cnt_d   = '0;
                m_d     = s_s;
                state_d = StCompute;
            end
            StCompute: begin
                // Arithmetic right shift of {sum, B} by one bit.
                x_d = sum[WIDTH];
                a_d = {sum[WIDTH], sum[WIDTH-1:1]};
                b_d = {sum[0], b_q[WIDTH-1:1]};
                if (last_step) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (run_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;
    assign Busy = (state_q == StRunInit) || (state_q == StCompute);

endmodule

// File: tb/tb_multiplier_seq_param.sv
module tb_multiplier_seq_param;

    localparam int unsigned SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n, run_n, clr_n;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        x8, x16, busy8, busy16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiplier_seq_param #(.WIDTH(8), .SYNC_STAGES(SYNC)) dut8 (
        .Clk(clk), .Reset_USH(rst_n), .Run_USH(run_n), .ClearA_LoadB_USH(clr_n),
        .S_USH(s8), .Aval(a8), .Bval(b8), .X(x8), .Busy(busy8)
    );

    multiplier_seq_param #(.WIDTH(16), .SYNC_STAGES(SYNC)) dut16 (
        .Clk(clk), .Reset_USH(rst_n), .Run_USH(run_n), .ClearA_LoadB_USH(clr_n),
        .S_USH(s16), .Aval(a16), .Bval(b16), .X(x16), .Busy(busy16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v8, input logic [15:0] v16);
        s8 = v8; s16 = v16; clr_n = 1'b0;
        tick(SYNC + 3);
        clr_n = 1'b1;
        tick(SYNC + 3);
    endtask

    // Presses Run and leaves it held; returns press-to-Busy latency and Busy lengths.
    task automatic do_run(input logic [7:0] v8, input logic [15:0] v16, input bit clr_mid,
                          output int lat, output int n8, output int n16);
        s8 = v8; s16 = v16; run_n = 1'b0;
        lat = 0; n8 = 0; n16 = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            if (busy8) begin
                n8++;
                if (lat == 0) lat = cyc;
            end
            if (busy16) n16++;
            if (clr_mid && lat != 0 && cyc == lat + 1) clr_n = 1'b0;
            if (clr_mid && lat != 0 && cyc == lat + 5) clr_n = 1'b1;
            if (lat != 0 && !busy8 && !busy16 && n16 > 0) break;
        end
    endtask

    task automatic release_run();
        run_n = 1'b1;
        tick(SYNC + 3);
    endtask

    initial begin
        int lat, n8, n16, hb, wt;
        rst_n = 1'b0; run_n = 1'b1; clr_n = 1'b1; s8 = '0; s16 = '0;
        tick(2);
        check("reset_a8", a8, 0);
        check("reset_b8", b8, 0);
        check("reset_x8", x8, 0);
        check("reset_busy8", busy8, 0);
        check("reset_ab16", {a16, b16}, 0);
        rst_n = 1'b1;
        tick(2);

        // -42 * 2 = -84 ; 0x7FFF * 0x7FFF
        load(8'hD6, 16'h7FFF);
        check("load_ab8", {a8, b8}, 16'h00D6);
        do_run(8'h02, 16'h7FFF, 1'b0, lat, n8, n16);
        check("t1_latency", lat, SYNC + 1);
        check("t1_busy8_len", n8, 9);
        check("t1_busy16_len", n16, 17);
        check("t1_a8", a8, 8'hFF);
        check("t1_b8", b8, 8'hAC);
        check("t1_x8", x8, 1);
        check("t1_ab16", {a16, b16}, 32'h3FFF_0001);
        check("t1_x16", x16, 0);

        // Holding Run must not start another multiply.
        hb = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy8 || busy16) hb++;
        end
        check("hold_no_retrigger", hb, 0);
        check("hold_result8", {a8, b8}, 16'hFFAC);
        release_run();

        // Re-run multiplies by the previous low half.
        do_run(8'h02, 16'h0001, 1'b0, lat, n8, n16);
`ifdef MULT_ACCUM_EN
        check("t2_ab8", {a8, b8}, 16'hFF57);
        check("t2_ab16", {a16, b16}, 32'h0000_4000);
`else
        check("t2_ab8", {a8, b8}, 16'hFF58);
        check("t2_ab16", {a16, b16}, 32'h0000_0001);
`endif
        release_run();

        // -128 * -128 ; 0xFFFF * 1
        load(8'h80, 16'hFFFF);
        do_run(8'h80, 16'h0001, 1'b0, lat, n8, n16);
        check("t3a_ab8", {a8, b8}, 16'h4000);
        check("t3a_x8", x8, 0);
        check("t3a_ab16", {a16, b16}, 32'hFFFF_FFFF);
        check("t3a_x16", x16, 1);
        release_run();

        // 127 * -128 ; -32768 * -32768
        load(8'h7F, 16'h8000);
        do_run(8'h80, 16'h8000, 1'b0, lat, n8, n16);
        check("t3b_ab8", {a8, b8}, 16'hC080);
        check("t3b_ab16", {a16, b16}, 32'h4000_0000);
        release_run();

        // ClearA_LoadB pressed during COMPUTE is ignored: 5 * -3 ; 3 * 5
        load(8'h05, 16'h0003);
        do_run(8'hFD, 16'h0005, 1'b1, lat, n8, n16);
        check("clr_mid_busy8_len", n8, 9);
        check("clr_mid_ab8", {a8, b8}, 16'hFFF1);
        check("clr_mid_ab16", {a16, b16}, 32'h0000_000F);
        release_run();

        // Asynchronous reset on the 4th COMPUTE cycle.
        s8 = 8'h03; s16 = 16'h0003; run_n = 1'b0;
        wt = 0;
        while (!busy8 && wt < 10) begin
            @(posedge clk); #1;
            wt++;
        end
        check("rst_mid_started", busy8, 1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_a8", a8, 0);
        check("rst_mid_b8", b8, 0);
        check("rst_mid_x8", x8, 0);
        check("rst_mid_busy8", busy8, 0);
        check("rst_mid_busy16", busy16, 0);
        run_n = 1'b1;
        #5;
        rst_n = 1'b1;
        tick(SYNC + 6);
        check("rst_mid_no_completion", {busy8, busy16, a8, b8}, 0);

        // Recovery after reset: 6 * -7 ; 6 * 7
        load(8'h06, 16'h0006);
        do_run(8'hF9, 16'h0007, 1'b0, lat, n8, n16);
        check("recover_ab8", {a8, b8}, 16'hFFD6);
        check("recover_ab16", {a16, b16}, 32'h0000_002A);
        check("recover_x8_sign", x8, a8[7]);
        release_run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
